// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared constants and types for the 64-bit LFSR test-sequence generator and
// checker.
//   LFSR_SEED      : first word of the sequence (all ones)
//   LFSR_TERMINAL  : last word of the sequence; its successor is LFSR_SEED
//   chk_state_t    : checker FSM state encoding
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam logic [63:0] LFSR_SEED     = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] LFSR_TERMINAL = 64'h9C69_8321_9672_4182;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/lfsr64_next.sv
// -----------------------------------------------------------------------------
// lfsr64_next
// Combinational successor function of the 64-bit LFSR test sequence.
// Shared by the generator and the checker so both agree on the sequence.
// Ports:
//   cur : current sequence word
//   nxt : word that follows cur (TERMINAL is followed by SEED)
// -----------------------------------------------------------------------------
module lfsr64_next
    import lfsr_pkg::*;
(
    input  logic [63:0] cur,
    output logic [63:0] nxt
);

    // Top nibble is the XOR feedback, the rest is a left rotate by one.
    assign nxt = (cur == LFSR_TERMINAL) ? LFSR_SEED :
                 {cur[62] ^ cur[61], cur[61] ^ cur[60],
                  cur[60] ^ cur[59], cur[59] ^ cur[58],
                  cur[58:0], cur[63]};

endmodule

// File: rtl/lfsr_seq_checker.sv
// -----------------------------------------------------------------------------
// lfsr_seq_checker
// Receive-side checker for the 64-bit LFSR test sequence. Self-synchronises to
// the incoming word stream, then flags and counts every departing word.
// Ports:
//   clock      : rising-edge clock
//   reset_     : asynchronous active-low reset
//   din        : received sequence word
//   din_valid  : din is sampled only when high
//   clr_cnt    : synchronous clear of err_count (wins over an increment)
//   locked     : checker is synchronised to the sequence
//   err        : one-cycle pulse per mismatching word while locked
//   err_count  : saturating count of mismatches seen while locked
//   wrap       : one-cycle pulse when TERMINAL is received correctly while locked
//
// state  | meaning
// -------+----------------------------------------------------------------
// HUNT   | no reference; next valid word seeds the expected word
// VERIFY | counting consecutive matches towards lock; reseed on a miss
// LOCKED | tracking; misses flywheel exp forward and are reported
// -----------------------------------------------------------------------------
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT    = 4,
    parameter int UNLOCK_MISSES = 3,
    parameter int ERR_W         = 16
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic [63:0]      din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic             wrap
);

    localparam int MC_W   = $clog2(LOCK_COUNT) + 1;
    localparam int MISS_W = $clog2(UNLOCK_MISSES) + 1;

    chk_state_t        state_q, state_d;
    logic [63:0]       exp_q, exp_d;
    logic [MC_W-1:0]   match_q, match_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [ERR_W-1:0]  count_d;
    logic              err_d, wrap_d, inc;
    logic [63:0]       nxt_din, nxt_exp;
    logic              hit;

    lfsr64_next u_next_din (.cur(din),   .nxt(nxt_din));
    lfsr64_next u_next_exp (.cur(exp_q), .nxt(nxt_exp));

    assign hit = (din == exp_q);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        inc     = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    exp_d   = nxt_din;
                    match_d = '0;
                    state_d = VERIFY;
                end
                VERIFY: begin
                    if (hit) begin
                        exp_d   = nxt_exp;
                        match_d = match_q + 1'b1;
                        if (match_d == MC_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        exp_d   = nxt_din;
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // exp always advances from itself while locked, so a
                    // corrupted word cannot drag the reference off-sequence.
                    exp_d = nxt_exp;
                    if (hit) begin
                        miss_d = '0;
                        wrap_d = (din == LFSR_TERMINAL);
                    end else begin
                        err_d = 1'b1;
                        inc   = 1'b1;
                        if ((miss_q + MISS_W'(1)) == MISS_W'(UNLOCK_MISSES)) begin
                            state_d = HUNT;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + MISS_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        count_d = err_count;
        if (clr_cnt)
            count_d = '0;
        else if (inc && (err_count != {ERR_W{1'b1}}))
            count_d = err_count + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q   <= HUNT;
            exp_q     <= LFSR_SEED;
            match_q   <= '0;
            miss_q    <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            locked    <= (state_d == LOCKED);
            err       <= err_d;
            wrap      <= wrap_d;
            err_count <= count_d;
        end
    end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
module tb_lfsr_seq_checker;
    import lfsr_pkg::*;

    logic        clock = 1'b0;
    logic        reset_ = 1'b0;
    logic [63:0] din = '0;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err, wrap;
    logic [15:0] err_count;
    logic        s_locked, s_err, s_wrap;
    logic [1:0]  s_count;

    int total = 0;
    int bad   = 0;

    lfsr_seq_checker dut (
        .clock(clock), .reset_(reset_), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .locked(locked), .err(err), .err_count(err_count),
        .wrap(wrap)
    );

    // Narrow counter instance: same stream, used to see saturation quickly.
    lfsr_seq_checker #(.ERR_W(2)) dut_sat (
        .clock(clock), .reset_(reset_), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .locked(s_locked), .err(s_err), .err_count(s_count),
        .wrap(s_wrap)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic logic [63:0] f_next(input logic [63:0] l);
        logic [63:0] s;
        if (l == LFSR_TERMINAL) return LFSR_SEED;
        s = (l << 1) | (l >> 63);
        for (int i = 0; i < 4; i++) s[63-i] = l[62-i] ^ l[61-i];
        return s;
    endfunction

    function automatic logic [63:0] f_prev(input logic [63:0] m);
        logic [63:0] l;
        l = m >> 1;
        l[63] = m[0];
        for (int i = 0; i < 4; i++) l[59+i] = m[60+i] ^ l[58+i];
        return l;
    endfunction

    int          m_mode;        // 0 hunting, 1 verifying, 2 locked
    logic [63:0] m_exp;
    int          m_run, m_miss, m_cnt, m_cnt2;
    bit          m_locked, m_err, m_wrap;

    task automatic model_reset();
        m_mode = 0; m_exp = LFSR_SEED; m_run = 0; m_miss = 0;
        m_cnt = 0; m_cnt2 = 0; m_locked = 0; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit v, input logic [63:0] d, input bit c);
        m_err = 0; m_wrap = 0;
        if (v) begin
            if (m_mode == 0) begin
                m_exp = f_next(d); m_run = 0; m_mode = 1;
            end else if (m_mode == 1) begin
                if (d == m_exp) begin
                    m_exp = f_next(m_exp); m_run++;
                    if (m_run == 4) begin m_mode = 2; m_miss = 0; end
                end else begin
                    m_exp = f_next(d); m_run = 0;
                end
            end else begin
                if (d == m_exp) begin
                    m_miss = 0; m_wrap = (d == LFSR_TERMINAL);
                end else begin
                    m_err = 1; m_miss++;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    if (m_miss == 3) begin m_mode = 0; m_miss = 0; end
                end
                m_exp = f_next(m_exp);
            end
        end
        if (c) begin m_cnt = 0; m_cnt2 = 0; end
        m_locked = (m_mode == 2);
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic check_model();
        chk("locked", 64'(locked), 64'(m_locked));
        chk("err", 64'(err), 64'(m_err));
        chk("wrap", 64'(wrap), 64'(m_wrap));
        chk("err_count", 64'(err_count), 64'(m_cnt));
        chk("sat_locked", 64'(s_locked), 64'(m_locked));
        chk("sat_count", 64'(s_count), 64'(m_cnt2));
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit v, input logic [63:0] d, input bit c);
        din_valid = v; din = d; clr_cnt = c;
        @(posedge clock);
        model_step(v, d, c);
        #1;
    endtask

    logic [63:0] tx;
    localparam int K_OK = 0, K_BAD = 1, K_IDLE = 2;

    task automatic send(input int kind, input bit c);
        case (kind)
            K_OK:    begin cycle(1'b1, tx, c); tx = f_next(tx); end
            K_BAD:   begin cycle(1'b1, tx ^ 64'h1, c); tx = f_next(tx); end
            default: cycle(1'b0, {$urandom(), $urandom()}, c);
        endcase
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        #1;
        chk("rst_locked", 64'(locked), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_wrap", 64'(wrap), 64'h0);
        chk("rst_count", 64'(err_count), 64'h0);
        model_reset();
        #1 reset_ = 1'b1;
    endtask

    typedef struct {
        int kind; bit clr; bit locked; bit err; bit wrap; int cnt;
    } vec_t;
    vec_t tbl[$];

    initial begin
        int rise_at, wraps, wrap_word, burst, r;
        logic [63:0] mask;

        tbl.push_back('{K_OK,  0, 0, 0, 0, 0});
        tbl.push_back('{K_OK,  0, 0, 0, 0, 0});
        tbl.push_back('{K_OK,  0, 0, 0, 0, 0});
        tbl.push_back('{K_OK,  0, 0, 0, 0, 0});
        tbl.push_back('{K_OK,  0, 1, 0, 0, 0});
        tbl.push_back('{K_OK,  0, 1, 0, 0, 0});
        tbl.push_back('{K_BAD, 0, 1, 1, 0, 1});
        tbl.push_back('{K_OK,  0, 1, 0, 0, 1});
        tbl.push_back('{K_OK,  1, 1, 0, 0, 0});
        tbl.push_back('{K_BAD, 0, 1, 1, 0, 1});
        tbl.push_back('{K_BAD, 0, 1, 1, 0, 2});
        tbl.push_back('{K_BAD, 0, 0, 1, 0, 3});
        tbl.push_back('{K_OK,  0, 0, 0, 0, 3});
        tbl.push_back('{K_OK,  0, 0, 0, 0, 3});
        tbl.push_back('{K_OK,  0, 0, 0, 0, 3});
        tbl.push_back('{K_OK,  0, 0, 0, 0, 3});
        tbl.push_back('{K_OK,  0, 1, 0, 0, 3});
        tbl.push_back('{K_IDLE,0, 1, 0, 0, 3});
        tbl.push_back('{K_IDLE,0, 1, 0, 0, 3});

        model_reset();
        tx = LFSR_SEED;
        #12;
        chk("reset_locked", 64'(locked), 64'h0);
        chk("reset_err", 64'(err), 64'h0);
        chk("reset_wrap", 64'(wrap), 64'h0);
        chk("reset_count", 64'(err_count), 64'h0);
        reset_ = 1'b1;
        @(posedge clock); #1;

        // Table: lock from seed, single flip, clear, triple miss, relock.
        foreach (tbl[i]) begin
            send(tbl[i].kind, tbl[i].clr);
            chk($sformatf("tbl%0d_locked", i), 64'(locked), 64'(tbl[i].locked));
            chk($sformatf("tbl%0d_err", i), 64'(err), 64'(tbl[i].err));
            chk($sformatf("tbl%0d_wrap", i), 64'(wrap), 64'(tbl[i].wrap));
            chk($sformatf("tbl%0d_count", i), 64'(err_count), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_sat", i), 64'(s_count), 64'(m_cnt2));
        end

        // Clear coinciding with a mismatch: err pulses, count stays 0.
        send(K_BAD, 1'b1);
        chk("clr_vs_inc_err", 64'(err), 64'h1);
        chk("clr_vs_inc_count", 64'(err_count), 64'h0);
        chk("clr_vs_inc_locked", 64'(locked), 64'h1);
        send(K_BAD, 1'b0);
        chk("pre_reset_count", 64'(err_count), 64'h1);
        chk("pre_reset_locked", 64'(locked), 64'h1);

        // Asynchronous reset while locked, then wrap through TERMINAL.
        do_reset();
        tx = LFSR_TERMINAL;
        for (int i = 0; i < 8; i++) tx = f_prev(tx);
        wraps = 0; wrap_word = 0;
        for (int w = 1; w <= 12; w++) begin
            send(K_OK, 1'b0);
            check_model();
            if (w == 4) chk("relock_w4", 64'(locked), 64'h0);
            if (w == 5) chk("relock_w5", 64'(locked), 64'h1);
            if (wrap) begin wraps++; wrap_word = w; end
        end
        chk("wrap_pulses", 64'(wraps), 64'h1);
        chk("wrap_word", 64'(wrap_word), 64'd9);
        chk("wrap_lock_kept", 64'(locked), 64'h1);

        // Valid gaps: lock still needs exactly five valid words.
        for (int trial = 0; trial < 3; trial++) begin
            do_reset();
            tx = {$urandom(), $urandom()};
            rise_at = 0;
            for (int w = 1; w <= 7; w++) begin
                r = $urandom_range(7, 1);
                for (int g = 0; g < r; g++) begin
                    send(K_IDLE, 1'b0);
                    check_model();
                end
                send(K_OK, 1'b0);
                check_model();
                if (locked && rise_at == 0) rise_at = w;
            end
            chk("gap_lock_word", 64'(rise_at), 64'd5);
        end

        // Randomised soak against the model.
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(3) == 0) begin
                send(K_IDLE, 1'b0);
            end else begin
                r = $urandom_range(99);
                mask = {$urandom(), $urandom()};
                if (mask == 0) mask = 64'h1;
                if (burst == 0 && r < 2) burst = 3 + $urandom_range(1);
                if (burst > 0 || r < 10) begin
                    if (burst > 0) burst--;
                    cycle(1'b1, tx ^ mask, $urandom_range(49) == 0);
                    tx = f_next(tx);
                end else begin
                    if (r < 12) tx = f_next(tx);
                    cycle(1'b1, tx, $urandom_range(49) == 0);
                    tx = f_next(tx);
                end
            end
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_checker.md
# lfsr_seq_checker

- Receive-side checker for the 64-bit LFSR test sequence. Samples a 64-bit word stream, self-synchronises to it, then flags and counts every word that departs from the sequence.
- Sits at the far end of a link or datapath driven by the team's 64-bit LFSR generator. Used for link bring-up and BER-style soak tests.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive matching words, after the seed word, required to declare lock.
- UNLOCK_MISSES, 3: consecutive mismatching words while locked that force loss of lock.
- ERR_W, 16: width of the error counter.

Ports:
- clock  input  1: rising-edge clock.
- reset_  input  1: asynchronous, active-low reset.
- din  input  64: received sequence word.
- din_valid  input  1: din is sampled only when this is high.
- clr_cnt  input  1: synchronous clear of err_count.
- locked  output  1: checker is synchronised to the sequence.
- err  output  1: one-cycle pulse per mismatching word while locked.
- err_count  output  ERR_W: saturating count of mismatches seen while locked.
- wrap  output  1: one-cycle pulse when the terminal word is received correctly while locked.

## Operation
Sequence rule, with L the current word and N(L) the next word:
- If L == TERMINAL (64'h9C69_8321_9672_4182), then N = SEED (all ones).
- Otherwise N = {L[62]^L[61], L[61]^L[60], L[60]^L[59], L[59]^L[58], L[58:0], L[63]}.

Internal state: 64-bit register `exp` (the expected word) and a 2-bit FSM with states HUNT, VERIFY, LOCKED.

FSM behaviour, evaluated only on cycles where din_valid=1:
- HUNT: exp <= N(din); match counter <= 0; go to VERIFY.
- VERIFY, din == exp:
  - exp <= N(exp); match counter increments.
  - When the counter reaches LOCK_COUNT, go to LOCKED and set locked=1.
- VERIFY, din != exp: reseed with exp <= N(din) and match counter <= 0; stay in VERIFY. err is not pulsed.
- LOCKED, din == exp:
  - exp <= N(exp); miss counter <= 0.
  - If din == TERMINAL, pulse wrap.
- LOCKED, din != exp (flywheel):
  - exp <= N(exp), so exp advances from its own value, not from din.
  - Pulse err; err_count increments, saturating at all ones; miss counter increments.
- LOCKED, on reaching UNLOCK_MISSES: go to HUNT and clear locked. This happens in the same update that records the final miss, and err still pulses for that word.

Other behaviour:
- din_valid=0: all state holds; err=0 and wrap=0.
- clr_cnt: err_count <= 0. If clr_cnt coincides with an increment, the clear wins.
- Reset values: FSM=HUNT, exp=SEED, both counters 0, locked=0, err=0, wrap=0, err_count=0.
- Reset asserted mid-operation forces all of the above immediately (asynchronously).

## Timing
- All outputs are registered. err, wrap and the locked transitions appear one clock after the din_valid cycle that causes them.
- Lock latency: locked rises on the edge after the (LOCK_COUNT+1)-th consecutive valid word. The first word is the seed.
- Unlock latency: locked falls on the edge after the UNLOCK_MISSES-th consecutive bad word.
- Sustained throughput is one word per clock; there is no backpressure.
- Internal counter widths are $clog2 of the parameter plus 1; they never wrap.

## Structure
- Package lfsr_pkg holds:
  - LFSR_SEED (64'hFFFF_FFFF_FFFF_FFFF) and LFSR_TERMINAL (64'h9C69_8321_9672_4182);
  - the FSM state enum (HUNT, VERIFY, LOCKED).
- Sub-module lfsr64_next: purely combinational N(L), including the terminal-to-seed rule. It is instantiated twice, once on din and once on exp, and is reusable by the generator.

## Test plan
- Reset, then stream FFFF_FFFF_FFFF_FFFF, 0FFF_FFFF_FFFF_FFFF, 2FFF_FFFF_FFFF_FFFE and successors on consecutive cycles -> locked=1 one edge after the 5th word; err never asserts; err_count=0.
- While locked, flip bit 0 of one word -> err high for exactly one cycle; err_count=1; locked stays 1; the following correct word raises no err (flywheel holds).
- While locked, corrupt 3 consecutive words -> 3 err pulses; err_count=3; locked falls after the 3rd; the next correct stream relocks after 5 words.
- Stream reaching 9C69_8321_9672_4182 followed by FFFF_FFFF_FFFF_FFFF -> one wrap pulse; no err; lock retained.
- Insert random din_valid=0 gaps of 1–7 cycles in a correct stream -> identical lock timing counted in valid words; no spurious err or wrap.
- Assert clr_cnt in the same cycle as a mismatch, giving err=1 and err_count=0. Then drop reset_ while locked -> all outputs 0 immediately, and the FSM is back in HUNT.
